// File: rtl/video_timing_pkg.sv
// Shared HD raster timing constants and frame-lock state encoding.
package video_timing_pkg;

  localparam int unsigned H_W = 12;
  localparam int unsigned V_W = 11;

  localparam int unsigned HD_CLK_DIV   = 2;
  localparam int unsigned HD_H_ACT     = 1360;
  localparam int unsigned HD_H_FP      = 64;
  localparam int unsigned HD_H_SYNC    = 112;
  localparam int unsigned HD_H_BP      = 256;
  localparam int unsigned HD_V_ACT     = 768;
  localparam int unsigned HD_V_FP      = 3;
  localparam int unsigned HD_V_SYNC    = 6;
  localparam int unsigned HD_V_BP      = 18;
  localparam int unsigned HD_LOCK_LINE = 768;
  localparam int unsigned HD_LOCK_TOL  = 2;

  localparam int unsigned H_TOTAL = HD_H_ACT + HD_H_FP + HD_H_SYNC + HD_H_BP;
  localparam int unsigned V_TOTAL = HD_V_ACT + HD_V_FP + HD_V_SYNC + HD_V_BP;

  typedef enum logic [1:0] {
    LOCK_FREE  = 2'd0,
    LOCK_PEND  = 2'd1,
    LOCK_APPLY = 2'd2
  } lock_state_e;

  function automatic logic [V_W-1:0] abs_diff(input logic [V_W-1:0] a,
                                               input logic [V_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_window_dec.sv
// Registered window decode: o_win follows start <= pos < stop of the next position,
// so it lines up with the position register it shadows.
module sync_window_dec
  import video_timing_pkg::*;
#(
  parameter int unsigned W     = H_W,
  parameter int unsigned START = 0,
  parameter int unsigned STOP  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_pos_d,
  output logic         o_win
);

  logic win_d;
  logic win_q;

  generate
    if (START == 0) begin : g_from_zero
      always_comb win_d = (i_pos_d < W'(STOP));
    end else begin : g_window
      always_comb win_d = (i_pos_d >= W'(START)) && (i_pos_d < W'(STOP));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) win_q <= 1'b0;
    else     win_q <= win_d;
  end

  assign o_win = win_q;

endmodule

// File: rtl/hd_timing_gen.sv
// HD raster generator: pixel divider, h/v counters, sync/DE decode and an optional
// frame lock that pulls v_pos to LOCK_LINE after an out-of-tolerance PAL frame end.
module hd_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = HD_CLK_DIV,
  parameter int unsigned H_ACT     = HD_H_ACT,
  parameter int unsigned H_FP      = HD_H_FP,
  parameter int unsigned H_SYNC    = HD_H_SYNC,
  parameter int unsigned H_BP      = HD_H_BP,
  parameter int unsigned V_ACT     = HD_V_ACT,
  parameter int unsigned V_FP      = HD_V_FP,
  parameter int unsigned V_SYNC    = HD_V_SYNC,
  parameter int unsigned V_BP      = HD_V_BP,
  parameter int unsigned LOCK_LINE = HD_LOCK_LINE,
  parameter int unsigned LOCK_TOL  = HD_LOCK_TOL
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_lock_en,
  input  logic           i_frame_end,
  output logic           o_pix_en,
  output logic           o_hd_clk,
  output logic           o_hd_hsync,
  output logic           o_hd_vsync,
  output logic           o_hd_de,
  output logic [H_W-1:0] o_h_pos,
  output logic [V_W-1:0] o_v_pos,
  output logic           o_locked
);

  localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  logic             pix_en_q, pix_en_d;
  logic             hd_clk_q, hd_clk_d;
  logic             err_big_q, err_big_d;
  logic [1:0]       lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  lock_state_e      state_q, state_d;

  logic             pix_en_c;
  logic             wrap_c;
  logic             accept_c;
  logic             jump_c;
  logic             in_tol_c;
  logic             h_act, v_act;

  // Pixel divider; strobe and square wave are registered decodes of the next count.
  always_comb begin
    pix_en_c = (div_q == DIV_W'(CLK_DIV - 1));
    div_d    = pix_en_c ? '0 : div_q + DIV_W'(1);
    pix_en_d = (div_d == DIV_W'(CLK_DIV - 1));
    hd_clk_d = (div_d < DIV_W'(CLK_DIV / 2));
    wrap_c   = pix_en_c && (h_q == H_W'(H_TOT - 1));
  end

  // Raster counters; a lock jump only replaces the v increment at a line wrap.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_c) begin
      if (wrap_c) begin
        h_d = '0;
        if (jump_c)                           v_d = V_W'(LOCK_LINE);
        else if (v_q == V_W'(V_TOT - 1))      v_d = '0;
        else                                  v_d = v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
      end
    end
  end

  // Lock FSM: next state.
  always_comb begin
    state_d = state_q;
    if (!i_lock_en) begin
      state_d = LOCK_FREE;
    end else begin
      case (state_q)
        LOCK_FREE, LOCK_APPLY: state_d = i_frame_end ? LOCK_PEND : LOCK_FREE;
        LOCK_PEND: begin
          if (wrap_c) state_d = err_big_q ? LOCK_APPLY : LOCK_FREE;
        end
        default:               state_d = LOCK_FREE;
      endcase
    end
  end

  // Lock FSM: outputs (pulse acceptance and the v jump).
  always_comb begin
    accept_c = i_lock_en && i_frame_end && (state_q != LOCK_PEND);
    jump_c   = i_lock_en && (state_q == LOCK_PEND) && wrap_c && err_big_q;
  end

  // Tolerance tracking against the line seen at the accepted pulse.
  always_comb begin
    in_tol_c   = (abs_diff(v_q, V_W'(LOCK_LINE)) <= V_W'(LOCK_TOL));
    err_big_d  = accept_c ? !in_tol_c : err_big_q;
    lock_cnt_d = lock_cnt_q;
    if (!i_lock_en) begin
      lock_cnt_d = 2'd0;
    end else if (accept_c) begin
      if (!in_tol_c)               lock_cnt_d = 2'd0;
      else if (lock_cnt_q != 2'd2) lock_cnt_d = lock_cnt_q + 2'd1;
    end
    locked_d = (lock_cnt_d == 2'd2);
  end

  // Lock FSM: state register, plus the datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOCK_FREE;
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      pix_en_q   <= 1'b0;
      hd_clk_q   <= 1'b0;
      err_big_q  <= 1'b0;
      lock_cnt_q <= 2'd0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      pix_en_q   <= pix_en_d;
      hd_clk_q   <= hd_clk_d;
      err_big_q  <= err_big_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  sync_window_dec #(.W(H_W), .START(H_ACT + H_FP), .STOP(H_ACT + H_FP + H_SYNC)) u_hsync (
    .clk(clk), .rst(rst), .i_pos_d(h_d), .o_win(o_hd_hsync)
  );

  sync_window_dec #(.W(V_W), .START(V_ACT + V_FP), .STOP(V_ACT + V_FP + V_SYNC)) u_vsync (
    .clk(clk), .rst(rst), .i_pos_d(v_d), .o_win(o_hd_vsync)
  );

  sync_window_dec #(.W(H_W), .START(0), .STOP(H_ACT)) u_h_act (
    .clk(clk), .rst(rst), .i_pos_d(h_d), .o_win(h_act)
  );

  sync_window_dec #(.W(V_W), .START(0), .STOP(V_ACT)) u_v_act (
    .clk(clk), .rst(rst), .i_pos_d(v_d), .o_win(v_act)
  );

  assign o_hd_de  = h_act & v_act;
  assign o_pix_en = pix_en_q;
  assign o_hd_clk = hd_clk_q;
  assign o_h_pos  = h_q;
  assign o_v_pos  = v_q;
  assign o_locked = locked_q;

endmodule

// File: tb/tb_hd_timing_gen.sv
// Scoreboard bench for hd_timing_gen on a 14x7 raster: a pixel-index model predicts every
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_hd_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int LL = 4, TOL = 0;
  localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;

  typedef struct {
    bit pix; bit hdclk; bit hs; bit vs; bit de; bit locked;
    int h; int v;
    string tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lock_en = 1'b0;
  logic        fe = 1'b0;
  logic        pix_en, hd_clk, hsync, vsync, de, locked;
  logic [11:0] h_pos;
  logic [10:0] v_pos;

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "reset";
  exp_t  exp_q[$];

  // pixel index within the frame, divider phase, lock bookkeeping
  int m_p = 0, m_div = 0, m_cnt = 0;
  bit m_pend = 0, m_errbig = 0, m_rst = 1;

  hd_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .LOCK_LINE(LL), .LOCK_TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst), .i_lock_en(lock_en), .i_frame_end(fe),
    .o_pix_en(pix_en), .o_hd_clk(hd_clk), .o_hd_hsync(hsync), .o_hd_vsync(vsync),
    .o_hd_de(de), .o_h_pos(h_pos), .o_v_pos(v_pos), .o_locked(locked)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    exp_t e;
    int   h, v, err;
    bit   pix, wrap, jump, was_pend;
    if (rst) begin
      m_p = 0; m_div = 0; m_cnt = 0; m_pend = 0; m_errbig = 0; m_rst = 1;
    end else begin
      h = m_p % HT;
      v = m_p / HT;
      pix  = (m_div == CLK_DIV - 1);
      wrap = pix && (h == HT - 1);
      jump = 0;
      if (!lock_en) begin
        m_pend = 0;
        m_cnt  = 0;
      end else begin
        was_pend = m_pend;
        if (m_pend && wrap) begin
          jump   = m_errbig;
          m_pend = 0;
        end
        if (fe && !was_pend) begin
          err      = (v > LL) ? v - LL : LL - v;
          m_errbig = (err > TOL);
          m_cnt    = (err <= TOL) ? ((m_cnt == 2) ? 2 : m_cnt + 1) : 0;
          m_pend   = 1;
        end
      end
      if (pix) m_p = jump ? LL * HT : (m_p + 1) % (HT * VT);
      m_div = (m_div + 1) % CLK_DIV;
      m_rst = 0;
    end
    e.tag = phase;
    if (m_rst) begin
      e.pix = 0; e.hdclk = 0; e.hs = 0; e.vs = 0; e.de = 0; e.locked = 0; e.h = 0; e.v = 0;
    end else begin
      e.h      = m_p % HT;
      e.v      = m_p / HT;
      e.pix    = (m_div == CLK_DIV - 1);
      e.hdclk  = (m_div < CLK_DIV / 2);
      e.hs     = (e.h >= H_ACT + H_FP) && (e.h < H_ACT + H_FP + H_SYNC);
      e.vs     = (e.v >= V_ACT + V_FP) && (e.v < V_ACT + V_FP + V_SYNC);
      e.de     = (e.h < H_ACT) && (e.v < V_ACT);
      e.locked = (m_cnt == 2);
    end
    exp_q.push_back(e);
  endtask

  // Reference model: one prediction per active edge.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (pix_en !== e.pix || hd_clk !== e.hdclk || hsync !== e.hs || vsync !== e.vs ||
          de !== e.de || locked !== e.locked || int'(h_pos) != e.h || int'(v_pos) != e.v) begin
        n_fail++;
        $display("FAIL %s t=%0t got pix=%b clk=%b hs=%b vs=%b de=%b lk=%b h=%0d v=%0d want pix=%b clk=%b hs=%b vs=%b de=%b lk=%b h=%0d v=%0d",
                 e.tag, $time, pix_en, hd_clk, hsync, vsync, de, locked, h_pos, v_pos,
                 e.pix, e.hdclk, e.hs, e.vs, e.de, e.locked, e.h, e.v);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    fe = 1'b1;
    cyc();
    fe = 1'b0;
  endtask

  // Advance until the model (hence the DUT) sits at pixel (h,v); bounded.
  task automatic wait_at(input int h, input int v);
    for (int i = 0; i < 600; i++) begin
      if (!m_rst && (m_p % HT) == h && (m_p / HT) == v) return;
      cyc();
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_at(%0d,%0d) not reached in %s: model h=%0d v=%0d", h, v, phase,
             m_p % HT, m_p / HT);
  endtask

  initial begin
    repeat (3) cyc();
    rst = 1'b0;

    phase = "free_run";
    repeat (400) cyc();
    pulse();
    repeat (50) cyc();

    phase = "jump_from_v1";
    lock_en = 1'b1;
    wait_at(0, 0);
    wait_at(3, 1);
    pulse();
    repeat (40) cyc();

    phase = "in_tol_lock";
    wait_at(0, 0);
    wait_at(2, 4);
    pulse();
    wait_at(0, 0);
    wait_at(2, 4);
    pulse();
    repeat (10) cyc();
    phase = "lock_lost";
    wait_at(0, 0);
    wait_at(3, 2);
    pulse();
    repeat (40) cyc();

    phase = "double_pulse";
    wait_at(0, 0);
    wait_at(1, 1);
    pulse();
    repeat (4) cyc();
    pulse();
    repeat (40) cyc();

    phase = "lock_en_cancel";
    wait_at(0, 0);
    wait_at(1, 1);
    pulse();
    repeat (3) cyc();
    lock_en = 1'b0;
    repeat (2) cyc();
    lock_en = 1'b1;
    repeat (60) cyc();

    phase = "wrap_coincide";
    wait_at(0, 0);
    wait_at(HT - 1, 1);
    if (m_div != CLK_DIV - 1) cyc();
    pulse();
    repeat (60) cyc();

    phase = "mid_frame_rst";
    wait_at(6, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (250) cyc();

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      fe = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 299) == 0) lock_en = ~lock_en;
      rst = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    fe = 1'b0;
    rst = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    #1;

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
